// File: rtl/readout_pkg.sv
// Shared widths, state encoding and configuration record for the readout sequencer.
package readout_pkg;

  localparam int DELAY_W         = 14;
  localparam int LEN_W           = 11;
  localparam int SHOT_W          = 10;
  localparam int IQ_W            = 32;
  localparam int ACC_W           = IQ_W + SHOT_W;
  localparam int TIMEOUT_CYC_DEF = 4096;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DELAY    = 3'd1,
    ST_COLLECT  = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_ARM      = 3'd4,
    ST_OUTPUT   = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic [DELAY_W-1:0] delay;
    logic [LEN_W-1:0]   length;
    logic [SHOT_W-1:0]  shots;
  } readout_cfg_t;

  localparam readout_cfg_t CFG_RST = '{
    delay:  DELAY_W'(5000),
    length: LEN_W'(2000),
    shots:  SHOT_W'(1)
  };

endpackage

// File: rtl/iq_accumulator.sv
// Signed I/Q sum over shots; clear wins over add.
module iq_accumulator
  import readout_pkg::*;
(
  input  logic                    clk100,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    add_en,
  input  logic signed [IQ_W-1:0]  i_in,
  input  logic signed [IQ_W-1:0]  q_in,
  output logic signed [ACC_W-1:0] sum_i,
  output logic signed [ACC_W-1:0] sum_q
);

  logic signed [ACC_W-1:0] i_ext;
  logic signed [ACC_W-1:0] q_ext;

  assign i_ext = {{(ACC_W-IQ_W){i_in[IQ_W-1]}}, i_in};
  assign q_ext = {{(ACC_W-IQ_W){q_in[IQ_W-1]}}, q_in};

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      sum_i <= '0;
      sum_q <= '0;
    end else if (clear) begin
      sum_i <= '0;
      sum_q <= '0;
    end else if (add_en) begin
      sum_i <= sum_i + i_ext;
      sum_q <= sum_q + q_ext;
    end
  end

endmodule

// File: rtl/readout_sequencer.sv
// Trigger -> delayed collection window -> per-shot IQ accumulation -> valid/ready result.
// Handshake: a result transfers on any cycle with res_valid && res_ready; res_* hold until then.
module readout_sequencer
  import readout_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                    clk100,
  input  logic                    reset_n,
  input  logic                    cfg_load,
  input  logic [DELAY_W-1:0]      cfg_delay,
  input  logic [LEN_W-1:0]        cfg_length,
  input  logic [SHOT_W-1:0]       cfg_shots,
  output logic                    cfg_ack,
  input  logic                    trigger,
  input  logic                    abort,
  output logic                    start_collect,
  output logic                    collect_active,
  input  logic                    iq_valid,
  input  logic signed [IQ_W-1:0]  i_val,
  input  logic signed [IQ_W-1:0]  q_val,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [ACC_W-1:0] res_i,
  output logic signed [ACC_W-1:0] res_q,
  output logic [SHOT_W-1:0]       res_shots,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [7:0]              trig_dropped,
  output seq_state_t              state_dbg
);

  localparam int TO_W = $clog2(TIMEOUT_CYC);

  seq_state_t         state_q, state_d;
  readout_cfg_t       cfg_q, cfg_new, cfg_eff;
  logic               cfg_take;
  logic               cfg_ack_q;
  logic [DELAY_W-1:0] dly_cnt_q, dly_cnt_d;
  logic [LEN_W-1:0]   len_cnt_q, len_cnt_d, len_eff;
  logic [SHOT_W-1:0]  shot_cnt_q, shot_cnt_d, shot_next;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               timeout_q, timeout_d;
  logic [7:0]         drop_q, drop_d;
  logic               trig_drop, acc_clear, acc_add;

  assign cfg_new  = '{delay: cfg_delay, length: cfg_length, shots: cfg_shots};
  assign cfg_take = cfg_load && (state_q == ST_IDLE);
  // A trigger arriving together with a load must see the freshly loaded shot count.
  assign cfg_eff   = cfg_take ? cfg_new : cfg_q;
  assign len_eff   = (cfg_q.length == '0) ? LEN_W'(1) : cfg_q.length;
  assign shot_next = shot_cnt_q + SHOT_W'(1);

  always_comb begin
    state_d        = state_q;
    dly_cnt_d      = dly_cnt_q;
    len_cnt_d      = len_cnt_q;
    shot_cnt_d     = shot_cnt_q;
    to_cnt_d       = to_cnt_q;
    timeout_d      = timeout_q;
    trig_drop      = 1'b0;
    acc_clear      = 1'b0;
    acc_add        = 1'b0;
    start_collect  = 1'b0;
    collect_active = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          if (cfg_eff.shots != '0) begin
            state_d    = ST_DELAY;
            dly_cnt_d  = '0;
            shot_cnt_d = '0;
            acc_clear  = 1'b1;
          end else begin
            trig_drop = 1'b1;
          end
        end
      end
      ST_DELAY: begin
        trig_drop = trigger;
        if (dly_cnt_q == cfg_q.delay) begin
          // The start cycle is the first cycle of the window.
          start_collect  = 1'b1;
          collect_active = 1'b1;
          len_cnt_d      = LEN_W'(1);
          to_cnt_d       = '0;
          state_d        = (len_eff == LEN_W'(1)) ? ST_WAIT_RES : ST_COLLECT;
        end else begin
          dly_cnt_d = dly_cnt_q + DELAY_W'(1);
        end
      end
      ST_COLLECT: begin
        trig_drop      = trigger;
        collect_active = 1'b1;
        if (len_cnt_q == len_eff - LEN_W'(1)) begin
          state_d  = ST_WAIT_RES;
          to_cnt_d = '0;
        end else begin
          len_cnt_d = len_cnt_q + LEN_W'(1);
        end
      end
      ST_WAIT_RES: begin
        trig_drop = trigger;
        if (iq_valid) begin
          acc_add    = 1'b1;
          shot_cnt_d = shot_next;
          state_d    = (shot_next == cfg_q.shots) ? ST_OUTPUT : ST_ARM;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          acc_clear = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_ARM: begin
        if (trigger) begin
          state_d   = ST_DELAY;
          dly_cnt_d = '0;
        end
      end
      ST_OUTPUT: begin
        trig_drop = trigger;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort cancels everything except a finished result waiting to drain.
    if (abort && (state_q != ST_IDLE) && (state_q != ST_OUTPUT)) begin
      state_d    = ST_IDLE;
      acc_clear  = 1'b1;
      acc_add    = 1'b0;
      shot_cnt_d = '0;
      timeout_d  = timeout_q;
    end
  end

  assign drop_d = (trig_drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cfg_q      <= CFG_RST;
      cfg_ack_q  <= 1'b0;
      dly_cnt_q  <= '0;
      len_cnt_q  <= '0;
      shot_cnt_q <= '0;
      to_cnt_q   <= '0;
      timeout_q  <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      cfg_ack_q  <= cfg_take;
      dly_cnt_q  <= dly_cnt_d;
      len_cnt_q  <= len_cnt_d;
      shot_cnt_q <= shot_cnt_d;
      to_cnt_q   <= to_cnt_d;
      timeout_q  <= timeout_d;
      drop_q     <= drop_d;
      if (cfg_take) cfg_q <= cfg_new;
    end
  end

  iq_accumulator u_acc (
    .clk100  (clk100),
    .reset_n (reset_n),
    .clear   (acc_clear),
    .add_en  (acc_add),
    .i_in    (i_val),
    .q_in    (q_val),
    .sum_i   (res_i),
    .sum_q   (res_q)
  );

  assign cfg_ack      = cfg_ack_q;
  assign res_valid    = (state_q == ST_OUTPUT);
  assign res_shots    = shot_cnt_q;
  assign busy         = (state_q != ST_IDLE);
  assign timeout_err  = timeout_q;
  assign trig_dropped = drop_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer: result scoreboard plus inline timing checks.
module tb_readout_sequencer;
  import readout_pkg::*;

  localparam int RW = 2*ACC_W + SHOT_W;

  logic                    clk100 = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    cfg_load = 1'b0;
  logic [DELAY_W-1:0]      cfg_delay = '0;
  logic [LEN_W-1:0]        cfg_length = '0;
  logic [SHOT_W-1:0]       cfg_shots = '0;
  logic                    cfg_ack;
  logic                    trigger = 1'b0;
  logic                    abort = 1'b0;
  logic                    start_collect;
  logic                    collect_active;
  logic                    iq_valid = 1'b0;
  logic signed [IQ_W-1:0]  i_val = '0;
  logic signed [IQ_W-1:0]  q_val = '0;
  logic                    res_valid;
  logic                    res_ready = 1'b1;
  logic signed [ACC_W-1:0] res_i;
  logic signed [ACC_W-1:0] res_q;
  logic [SHOT_W-1:0]       res_shots;
  logic                    busy;
  logic                    timeout_err;
  logic [7:0]              trig_dropped;
  seq_state_t              state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [RW-1:0] exp_q[$];

  readout_sequencer dut (
    .clk100         (clk100),
    .reset_n        (reset_n),
    .cfg_load       (cfg_load),
    .cfg_delay      (cfg_delay),
    .cfg_length     (cfg_length),
    .cfg_shots      (cfg_shots),
    .cfg_ack        (cfg_ack),
    .trigger        (trigger),
    .abort          (abort),
    .start_collect  (start_collect),
    .collect_active (collect_active),
    .iq_valid       (iq_valid),
    .i_val          (i_val),
    .q_val          (q_val),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_i          (res_i),
    .res_q          (res_q),
    .res_shots      (res_shots),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .trig_dropped   (trig_dropped),
    .state_dbg      (state_dbg)
  );

  // clock / watchdog
  always #5 clk100 = ~clk100;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic push_exp(input logic signed [ACC_W-1:0] ei, input logic signed [ACC_W-1:0] eq,
                          input logic [SHOT_W-1:0] es);
    exp_q.push_back({ei, eq, es});
  endtask

  task automatic do_cfg(input int d, input int l, input int s);
    cfg_delay  = DELAY_W'(d);
    cfg_length = LEN_W'(l);
    cfg_shots  = SHOT_W'(s);
    cfg_load   = 1'b1;
    tick();
    cfg_load = 1'b0;
    check("cfg_ack", ACC_W'(cfg_ack), ACC_W'(1));
  endtask

  task automatic do_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 1;
    while (!start_collect && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic count_window(output int m);
    m = 0;
    while (collect_active && m < 200) begin
      m++;
      tick();
    end
  endtask

  task automatic send_iq(input logic signed [IQ_W-1:0] i, input logic signed [IQ_W-1:0] q);
    iq_valid = 1'b1;
    i_val    = i;
    q_val    = q;
    tick();
    iq_valid = 1'b0;
  endtask

  task automatic run_shot(input int d, input int l, input logic signed [IQ_W-1:0] i,
                          input logic signed [IQ_W-1:0] q);
    int n;
    int m;
    do_trigger();
    wait_start(n);
    check("start_latency", ACC_W'(n), ACC_W'(d + 1));
    count_window(m);
    check("window_len", ACC_W'(m), ACC_W'(l));
    send_iq(i, q);
  endtask

  // scoreboard monitor: compares every transfer against the expected queue
  initial begin
    logic [RW-1:0] e;
    forever begin
      @(negedge clk100);
      if (reset_n && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got i=%0d q=%0d shots=%0d, expected none", res_i, res_q, res_shots);
        end else begin
          e = exp_q.pop_front();
          check("res_i", res_i, e[RW-1 -: ACC_W]);
          check("res_q", res_q, e[SHOT_W +: ACC_W]);
          check("res_shots", ACC_W'(res_shots), ACC_W'(e[SHOT_W-1:0]));
        end
      end
    end
  end

  initial begin
    int n;
    // reset state
    repeat (3) tick();
    check("rst_busy", ACC_W'(busy), ACC_W'(0));
    check("rst_start", ACC_W'(start_collect), ACC_W'(0));
    check("rst_collect", ACC_W'(collect_active), ACC_W'(0));
    check("rst_res_valid", ACC_W'(res_valid), ACC_W'(0));
    check("rst_res_i", res_i, ACC_W'(0));
    check("rst_timeout", ACC_W'(timeout_err), ACC_W'(0));
    check("rst_dropped", ACC_W'(trig_dropped), ACC_W'(0));
    check("rst_cfg_ack", ACC_W'(cfg_ack), ACC_W'(0));
    reset_n = 1'b1;
    tick();

    // basic single shot
    do_cfg(3, 4, 1);
    tick();
    check("cfg_ack_pulse", ACC_W'(cfg_ack), ACC_W'(0));
    push_exp(42'sd100, -42'sd50, 10'd1);
    run_shot(3, 4, 32'sd100, -32'sd50);
    check("res_valid_up", ACC_W'(res_valid), ACC_W'(1));
    tick();
    tick();

    // three shots averaged into one result, ARM between shots
    do_cfg(2, 1, 3);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) push_exp(-42'sd21, 42'sd6, 10'd3);
      run_shot(2, 1, -32'sd7, 32'sd2);
      if (k < 2) check("arm_state", ACC_W'(state_dbg), ACC_W'(ST_ARM));
    end
    tick();
    tick();

    // dropped trigger in DELAY, ignored load in COLLECT
    do_cfg(6, 3, 1);
    do_trigger();
    tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    wait_start(n);
    tick();
    cfg_delay  = DELAY_W'(1);
    cfg_length = LEN_W'(1);
    cfg_shots  = SHOT_W'(2);
    cfg_load   = 1'b1;
    tick();
    cfg_load = 1'b0;
    check("no_cfg_ack", ACC_W'(cfg_ack), ACC_W'(0));
    count_window(n);
    push_exp(42'sd5, 42'sd9, 10'd1);
    send_iq(32'sd5, 32'sd9);
    tick();
    check("trig_dropped", ACC_W'(trig_dropped), ACC_W'(1));
    push_exp(42'sd1, -42'sd1, 10'd1);
    run_shot(6, 3, 32'sd1, -32'sd1);
    tick();
    tick();

    // timeout in WAIT_RES
    do_cfg(0, 1, 1);
    do_trigger();
    wait_start(n);
    check("start_latency_d0", ACC_W'(n), ACC_W'(1));
    tick();
    check("wait_res_entry", ACC_W'(state_dbg), ACC_W'(ST_WAIT_RES));
    n = 0;
    while (!timeout_err && n < 5000) begin
      tick();
      n++;
    end
    check("timeout_cycles", ACC_W'(n), ACC_W'(4096));
    check("timeout_busy", ACC_W'(busy), ACC_W'(0));
    push_exp(-42'sd1, -42'sd2, 10'd1);
    run_shot(0, 1, -32'sd1, -32'sd2);
    tick();
    tick();

    // abort mid-window discards the earlier shot
    do_cfg(1, 4, 2);
    run_shot(1, 4, 32'sd1000, 32'sd1000);
    check("abort_pre_arm", ACC_W'(state_dbg), ACC_W'(ST_ARM));
    do_trigger();
    wait_start(n);
    check("abort_start", ACC_W'(n), ACC_W'(2));
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_collect", ACC_W'(collect_active), ACC_W'(0));
    check("abort_start_low", ACC_W'(start_collect), ACC_W'(0));
    check("abort_busy", ACC_W'(busy), ACC_W'(0));
    push_exp(42'sd6, 42'sd8, 10'd2);
    run_shot(1, 4, 32'sd3, 32'sd4);
    run_shot(1, 4, 32'sd3, 32'sd4);
    tick();
    tick();

    // backpressure: result held while inputs toggle
    do_cfg(0, 1, 1);
    res_ready = 1'b0;
    push_exp(-42'sd123456, 42'sd654321, 10'd1);
    run_shot(0, 1, -32'sd123456, 32'sd654321);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", ACC_W'(res_valid), ACC_W'(1));
      check("hold_i", res_i, -42'sd123456);
      check("hold_q", res_q, 42'sd654321);
      check("hold_shots", ACC_W'(res_shots), ACC_W'(1));
      iq_valid = 1'b1;
      i_val    = k[0] ? 32'sh7fffffff : -32'sd1;
      q_val    = k[0] ? -32'sd99 : 32'sd77;
      tick();
    end
    iq_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    check("drain_valid_low", ACC_W'(res_valid), ACC_W'(0));

    // async reset mid-DELAY
    do_cfg(10, 2, 1);
    do_trigger();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", ACC_W'(busy), ACC_W'(0));
    check("arst_start", ACC_W'(start_collect), ACC_W'(0));
    check("arst_collect", ACC_W'(collect_active), ACC_W'(0));
    check("arst_res_valid", ACC_W'(res_valid), ACC_W'(0));
    check("arst_timeout", ACC_W'(timeout_err), ACC_W'(0));
    check("arst_dropped", ACC_W'(trig_dropped), ACC_W'(0));
    check("arst_res_i", res_i, ACC_W'(0));
    tick();
    reset_n = 1'b1;
    repeat (5) tick();

    check("exp_q_empty", ACC_W'(exp_q.size()), ACC_W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
